// File: rtl/fdu_heartbeat.sv
// fdu_heartbeat: node-side transmitter of the 3-bit Gray heartbeat watched by the FDU.
//   The heartbeat advances every HB_PERIOD cycles while software keeps kicking. It freezes
//   when kicks stop (STARVED) or a fault is injected (HALTED). The FDU por line forces the
//   node back to BOOT.
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   kick         single-cycle software keep-alive pulse
//   fault_inject level, halts the heartbeat until por or reset
//   por_in       FDU power-on-reset for this node (asynchronous, synchronised here)
//   prime_in     FDU prime bit for this node (asynchronous, synchronised here)
//   hb           heartbeat code to the FDU
//   beat         one-cycle pulse coincident with each hb change
//   running      high while in RUN
//   is_prime     synchronised prime_in
//   miss_count   saturating count of RUN->STARVED events (cleared by reset only)
module fdu_heartbeat #(
  parameter int unsigned HB_PERIOD   = 50000,
  parameter int unsigned KICK_WINDOW = 25000000,
  parameter int unsigned BOOT_DELAY  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kick,
  input  logic       fault_inject,
  input  logic       por_in,
  input  logic       prime_in,
  output logic [2:0] hb,
  output logic       beat,
  output logic       running,
  output logic       is_prime,
  output logic [7:0] miss_count
);

  localparam int unsigned PerW  = $clog2(HB_PERIOD);
  localparam int unsigned KickW = $clog2(KICK_WINDOW);
  localparam int unsigned BootW = $clog2(BOOT_DELAY + 1);

  localparam logic [PerW-1:0]  PerLast  = PerW'(HB_PERIOD - 1);
  localparam logic [KickW-1:0] KickLast = KickW'(KICK_WINDOW - 1);
  localparam logic [BootW-1:0] BootLast = BootW'(BOOT_DELAY - 1);

  typedef enum logic [1:0] {StBoot, StRun, StStarved, StHalted} state_e;

  state_e           state_q, state_d;
  logic [BootW-1:0] boot_q, boot_d;
  logic [PerW-1:0]  per_q, per_d;
  logic [KickW-1:0] kick_cnt_q, kick_cnt_d;
  logic [2:0]       hb_q, hb_d;
  logic             beat_q, beat_d;
  logic             running_q, running_d;
  logic [7:0]       miss_q, miss_d;

  logic por_meta_q, por_s_q;
  logic prime_meta_q, prime_s_q, is_prime_q;

  // Next code in the wrapping Gray sequence 000,001,011,010,110,111,101,100.
  function automatic logic [2:0] gray_next(input logic [2:0] g);
    logic [2:0] n;
    case (g)
      3'b000:  n = 3'b001;
      3'b001:  n = 3'b011;
      3'b011:  n = 3'b010;
      3'b010:  n = 3'b110;
      3'b110:  n = 3'b111;
      3'b111:  n = 3'b101;
      3'b101:  n = 3'b100;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  // Two-flop synchronisers for the asynchronous FDU lines, plus the registered is_prime.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      por_meta_q   <= 1'b0;
      por_s_q      <= 1'b0;
      prime_meta_q <= 1'b0;
      prime_s_q    <= 1'b0;
      is_prime_q   <= 1'b0;
    end else begin
      por_meta_q   <= por_in;
      por_s_q      <= por_meta_q;
      prime_meta_q <= prime_in;
      prime_s_q    <= prime_meta_q;
      is_prime_q   <= prime_s_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_d     = boot_q;
    per_d      = per_q;
    kick_cnt_d = kick_cnt_q;
    hb_d       = hb_q;
    beat_d     = 1'b0;
    miss_d     = miss_q;

    if (por_s_q) begin
      state_d    = StBoot;
      boot_d     = '0;
      per_d      = '0;
      kick_cnt_d = '0;
      hb_d       = 3'b000;
    end else begin
      case (state_q)
        StBoot: begin
          if (boot_q == BootLast) begin
            state_d    = StRun;
            per_d      = '0;
            kick_cnt_d = '0;
          end else begin
            boot_d = boot_q + BootW'(1);
          end
        end
        StRun: begin
          if (fault_inject) begin
            state_d = StHalted;
          end else begin
            // Heartbeat advance and kick handling are independent of each other.
            if (per_q == PerLast) begin
              per_d  = '0;
              hb_d   = gray_next(hb_q);
              beat_d = 1'b1;
            end else begin
              per_d = per_q + PerW'(1);
            end
            if (kick) begin
              kick_cnt_d = '0;
            end else if (kick_cnt_q == KickLast) begin
              state_d = StStarved;
              if (miss_q != 8'hff) miss_d = miss_q + 8'd1;
            end else begin
              kick_cnt_d = kick_cnt_q + KickW'(1);
            end
          end
        end
        StStarved: begin
          if (fault_inject) begin
            state_d = StHalted;
          end else if (kick) begin
            state_d    = StRun;
            per_d      = '0;
            kick_cnt_d = '0;
          end
        end
        StHalted: begin
          // Only por or reset leaves HALTED.
        end
        default: state_d = StBoot;
      endcase
    end

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StBoot;
      boot_q     <= '0;
      per_q      <= '0;
      kick_cnt_q <= '0;
      hb_q       <= 3'b000;
      beat_q     <= 1'b0;
      running_q  <= 1'b0;
      miss_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      boot_q     <= boot_d;
      per_q      <= per_d;
      kick_cnt_q <= kick_cnt_d;
      hb_q       <= hb_d;
      beat_q     <= beat_d;
      running_q  <= running_d;
      miss_q     <= miss_d;
    end
  end

  assign hb         = hb_q;
  assign beat       = beat_q;
  assign running    = running_q;
  assign is_prime   = is_prime_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_fdu_heartbeat.sv
module tb_fdu_heartbeat;

  localparam int HP = 4;
  localparam int KW = 20;
  localparam int BD = 5;

  localparam int MBOOT = 0;
  localparam int MRUN  = 1;
  localparam int MSTV  = 2;
  localparam int MHLT  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       kick;
  logic       fault_inject;
  logic       por_in;
  logic       prime_in;
  logic [2:0] hb;
  logic       beat;
  logic       running;
  logic       is_prime;
  logic [7:0] miss_count;

  int n_cmp = 0;
  int n_err = 0;

  fdu_heartbeat #(
    .HB_PERIOD  (HP),
    .KICK_WINDOW(KW),
    .BOOT_DELAY (BD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .kick        (kick),
    .fault_inject(fault_inject),
    .por_in      (por_in),
    .prime_in    (prime_in),
    .hb          (hb),
    .beat        (beat),
    .running     (running),
    .is_prime    (is_prime),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: heartbeat is an index into the code table, delays are plain integers.
  typedef struct {
    bit por1, por2, pr1, pr2, isp;
    int st, boot, per, idle, idx, miss;
    bit beat, run;
  } mdl_t;

  mdl_t m;

  function automatic logic [2:0] code_of(input int i);
    logic [2:0] tbl [8];
    tbl = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    return tbl[i % 8];
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.por1 = 0; r.por2 = 0; r.pr1 = 0; r.pr2 = 0; r.isp = 0;
    r.st = MBOOT; r.boot = 0; r.per = 0; r.idle = 0; r.idx = 0; r.miss = 0;
    r.beat = 0; r.run = 0;
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t c, input bit k, input bit f, input bit p,
                                input bit pr);
    mdl_t n;
    n = c;
    n.por1 = p;  n.por2 = c.por1;
    n.pr1  = pr; n.pr2  = c.pr1; n.isp = c.pr2;
    n.beat = 0;
    if (c.por2) begin
      n.st = MBOOT; n.boot = 0; n.idx = 0; n.per = 0; n.idle = 0;
    end else if (c.st == MBOOT) begin
      if (c.boot + 1 >= BD) begin
        n.st = MRUN; n.per = 0; n.idle = 0;
      end else n.boot = c.boot + 1;
    end else if (c.st == MRUN) begin
      if (f) n.st = MHLT;
      else begin
        n.per = (c.per + 1) % HP;
        if (n.per == 0) begin
          n.idx = (c.idx + 1) % 8;
          n.beat = 1;
        end
        if (k) n.idle = 0;
        else if (c.idle + 1 >= KW) begin
          n.st = MSTV;
          n.miss = (c.miss + 1 > 255) ? 255 : c.miss + 1;
        end else n.idle = c.idle + 1;
      end
    end else if (c.st == MSTV) begin
      if (f) n.st = MHLT;
      else if (k) begin
        n.st = MRUN; n.per = 0; n.idle = 0;
      end
    end
    n.run = (n.st == MRUN);
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= mdl_reset();
    else       m <= step(m, kick, fault_inject, por_in, prime_in);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("mdl_hb", 32'(hb), 32'(code_of(m.idx)));
    chk("mdl_beat", 32'(beat), 32'(m.beat));
    chk("mdl_running", 32'(running), 32'(m.run));
    chk("mdl_is_prime", 32'(is_prime), 32'(m.isp));
    chk("mdl_miss", 32'(miss_count), 32'(m.miss));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic kick_pulse();
    kick = 1'b1;
    @(negedge clk);
    kick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; kick = 1'b0; fault_inject = 1'b0; por_in = 1'b0; prime_in = 1'b0;
    cyc(3);
    chk("rst_hb", 32'(hb), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_miss", 32'(miss_count), 32'h0);

    // Boot, then heartbeat stepping with kicks every 10 cycles, then starvation.
    reset = 1'b0;
    cyc(4);
    chk("boot_not_yet", 32'(running), 32'h0);
    cyc(1);
    chk("boot_running", 32'(running), 32'h1);
    for (int k = 1; k <= 51; k++) begin
      @(negedge clk);
      if (k == 3)  chk("hb_k3", 32'(hb), 32'h0);
      if (k == 4)  begin chk("hb_k4", 32'(hb), 32'h1); chk("beat_k4", 32'(beat), 32'h1); end
      if (k == 5)  chk("beat_k5", 32'(beat), 32'h0);
      if (k == 8)  chk("hb_k8", 32'(hb), 32'h3);
      if (k == 28) chk("hb_k28", 32'(hb), 32'h4);
      if (k == 32) chk("hb_wrap", 32'(hb), 32'h0);
      if (k == 50) chk("run_k50", 32'(running), 32'h1);
      if (k == 51) begin
        chk("starved", 32'(running), 32'h0);
        chk("miss_1", 32'(miss_count), 32'h1);
      end
      kick = ((k % 10) == 0) && (k <= 30);
    end
    kick = 1'b0;
    cyc(8);
    chk("hb_frozen", 32'(hb), 32'h6);

    // Kick out of STARVED: hb resumes from the frozen code after HB_PERIOD cycles.
    kick_pulse();
    chk("resume_run", 32'(running), 32'h1);
    cyc(3);
    chk("resume_hold", 32'(hb), 32'h6);
    cyc(1);
    chk("resume_hb", 32'(hb), 32'h7);

    // Kick lands exactly on the window-expiry cycle.
    cyc(15);
    kick_pulse();
    cyc(2);
    chk("edge_kick_run", 32'(running), 32'h1);
    chk("edge_kick_miss", 32'(miss_count), 32'h1);

    // Repeated starvation saturates miss_count.
    cyc(18);
    chk("starve2", 32'(running), 32'h0);
    chk("miss_2", 32'(miss_count), 32'h2);
    for (int i = 0; i < 259; i++) begin
      kick_pulse();
      cyc(20);
      if (i == 9) chk("miss_12", 32'(miss_count), 32'd12);
    end
    chk("miss_sat", 32'(miss_count), 32'd255);
    kick_pulse();

    // por in RUN; fault_inject during BOOT is ignored.
    por_in = 1'b1;
    cyc(2);
    chk("por_lat2", 32'(running), 32'h1);
    cyc(1);
    chk("por_run0", 32'(running), 32'h0);
    chk("por_hb0", 32'(hb), 32'h0);
    fault_inject = 1'b1;
    cyc(5);
    fault_inject = 1'b0;
    cyc(2);
    chk("por_hold", 32'(running), 32'h0);
    por_in = 1'b0;
    cyc(6);
    chk("por_boot", 32'(running), 32'h0);
    cyc(1);
    chk("por_rerun", 32'(running), 32'h1);
    chk("por_miss_kept", 32'(miss_count), 32'd255);

    // fault_inject in RUN halts; kicks are ignored.
    cyc(5);
    fault_inject = 1'b1;
    cyc(1);
    fault_inject = 1'b0;
    chk("halt_run0", 32'(running), 32'h0);
    for (int i = 0; i < 3; i++) begin
      kick_pulse();
      cyc(6);
    end
    chk("halt_hb", 32'(hb), 32'h1);
    chk("halt_still", 32'(running), 32'h0);
    por_in = 1'b1;
    cyc(1);
    por_in = 1'b0;
    cyc(6);
    chk("halt_por_boot", 32'(running), 32'h0);
    chk("halt_por_hb", 32'(hb), 32'h0);
    cyc(1);
    chk("halt_por_run", 32'(running), 32'h1);

    // prime_in follows with a 3-cycle delay.
    prime_in = 1'b1;
    cyc(2);
    chk("prime_lat", 32'(is_prime), 32'h0);
    cyc(1);
    chk("prime_up", 32'(is_prime), 32'h1);
    prime_in = 1'b0;
    cyc(2);
    chk("prime_hold", 32'(is_prime), 32'h1);
    cyc(1);
    chk("prime_down", 32'(is_prime), 32'h0);
    prime_in = 1'b1;
    cyc(5);
    kick_pulse();
    chk("pre_rst_run", 32'(running), 32'h1);
    chk("pre_rst_prime", 32'(is_prime), 32'h1);

    // Asynchronous reset mid-RUN.
    #2;
    reset = 1'b1;
    #1;
    chk("arst_hb", 32'(hb), 32'h0);
    chk("arst_beat", 32'(beat), 32'h0);
    chk("arst_running", 32'(running), 32'h0);
    chk("arst_prime", 32'(is_prime), 32'h0);
    chk("arst_miss", 32'(miss_count), 32'h0);
    prime_in = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(4);
    chk("rerst_boot", 32'(running), 32'h0);
    cyc(1);
    chk("rerst_run", 32'(running), 32'h1);
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
